// File: rtl/cpu_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns PC and IR, runs the fetch
// handshake, sequences execute/writeback and stops on ebreak or faults.
module cpu_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [2:0]  dec_type,
  output logic        exe_start,
  input  logic        exe_done,
  input  logic [31:0] next_pc,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halt,
  output logic [1:0]  halt_code
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] ret_q;
  logic [31:0] npc_q;
  logic [2:0]  type_q;
  logic        first_q;
  logic [1:0]  code_q;
  logic [1:0]  code_n;
  logic        ld_inst;
  logic        ld_type;
  logic        ld_npc;
  logic        commit;
  logic        wb_wen;

  always_comb begin
    state_n = state;
    code_n  = code_q;
    ld_inst = 1'b0;
    ld_type = 1'b0;
    ld_npc  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          ld_inst = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (inst_q == EBREAK) begin
          code_n  = 2'd0;
          state_n = S_HALT;
        end else if (dec_type >= 3'd6) begin
          code_n  = 2'd1;
          state_n = S_HALT;
        end else begin
          ld_type = 1'b1;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exe_done) begin
          ld_npc = 1'b1;
          if (next_pc[1:0] != 2'b00) begin
            code_n  = 2'd2;
            state_n = S_HALT;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        commit  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      first_q <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state   <= state_n;
      // EXEC is only ever entered from DECODE
      first_q <= (state == S_DECODE);
      code_q  <= code_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
      ret_q  <= '0;
      npc_q  <= RESET_PC;
      type_q <= '0;
    end else begin
      if (ld_inst) inst_q <= imem_rdata;
      if (ld_type) type_q <= dec_type;
      if (ld_npc)  npc_q  <= next_pc;
      if (commit) begin
        pc_q  <= npc_q;
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  // Only R, I, U and J write a destination register
  always_comb begin
    wb_wen = 1'b0;
    unique case (type_q)
      3'd0, 3'd1, 3'd4, 3'd5: wb_wen = 1'b1;
      default:                wb_wen = 1'b0;
    endcase
  end

  assign imem_req_valid = (state == S_FETCH);
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign retired        = ret_q;
  assign exe_start      = (state == S_EXEC) && first_q;
  assign rf_wen         = (state == S_WB) && wb_wen;
  assign halt           = (state == S_HALT);
  assign halt_code      = code_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: table vectors, reset corner cases and random
// instructions checked against a per-instruction reference model.
module tb_cpu_ctrl;

  localparam logic [31:0] RP     = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [2:0]  dec_type;
  logic        exe_start;
  logic        exe_done;
  logic [31:0] next_pc;
  logic        rf_wen;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halt;
  logic [1:0]  halt_code;

  cpu_ctrl #(.RESET_PC(RP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .dec_type       (dec_type),
    .exe_start      (exe_start),
    .exe_done       (exe_done),
    .next_pc        (next_pc),
    .rf_wen         (rf_wen),
    .pc             (pc),
    .retired        (retired),
    .halt           (halt),
    .halt_code      (halt_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  ty;
    logic [31:0] np;
    int          rd;
    int          sd;
    int          dd;
    bit          spur;
    bit          e_halt;
    logic [1:0]  e_code;
    bit          e_wen;
  } vec_t;

  int          tests;
  int          fails;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_inst;
  vec_t        tbl[12];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic clr_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    dec_type       = '0;
    exe_done       = 1'b0;
    next_pc        = '0;
  endtask

  // Called at a negedge; reset is checked 1 time unit later, before any edge
  task automatic do_reset();
    clr_inputs();
    imem_rsp_valid = 1'b1;
    imem_rdata     = EBREAK;
    rst = 1'b1;
    #1;
    chk("reset", 128'({imem_req_valid, imem_addr, inst, pc, retired,
                       halt, halt_code, exe_start, rf_wen}),
        128'({1'b1, RP, 32'h0, RP, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    clr_inputs();
    m_pc   = RP;
    m_ret  = '0;
    m_inst = '0;
  endtask

  // Drives one instruction through the handshakes with the given wait
  // counts and checks every cycle against the expected timeline.
  task automatic run_instr(input vec_t v);
    int kd;
    int ke;
    int kw;
    int kr;
    int last;
    kr = v.rd + v.sd + 1;
    kd = kr + 1;
    ke = kd + 1;
    kw = ke + v.dd + 1;
    if (v.e_halt && v.e_code != 2'd2) last = kd;
    else if (v.e_halt) last = kw - 1;
    else last = kw;
    for (int k = 0; k <= last; k++) begin
      imem_req_ready = (k == v.rd);
      imem_rsp_valid = (k == kr) || (v.spur && k == 0);
      imem_rdata     = (k == kr) ? v.ins : EBREAK;
      dec_type       = v.ty;
      exe_done       = (k == kw - 1);
      next_pc        = (k == kw - 1) ? v.np : 32'h0000_0003;
      #1;
      chk("ctl", 128'({imem_req_valid, exe_start, rf_wen, halt}),
          128'({k <= v.rd, k == ke, (k == kw) && v.e_wen, 1'b0}));
      chk("addr", 128'(imem_addr), 128'(m_pc));
      chk("regs", 128'({pc, retired, inst}),
          128'({m_pc, m_ret, (k > kr) ? v.ins : m_inst}));
      @(negedge clk);
    end
    m_inst = v.ins;
    if (v.e_halt) begin
      for (int i = 0; i < 20; i++) begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = i[0];
        imem_rdata     = 32'h0000_0013;
        exe_done       = 1'b1;
        next_pc        = 32'h8000_1000;
        #1;
        chk("halt", 128'({imem_req_valid, exe_start, rf_wen, halt,
                          halt_code, pc, retired, inst}),
            128'({3'b000, 1'b1, v.e_code, m_pc, m_ret, m_inst}));
        @(negedge clk);
      end
    end else begin
      m_pc  = v.np;
      m_ret = m_ret + 32'd1;
    end
  endtask

  function automatic vec_t rand_vec(input logic [31:0] cur_pc);
    vec_t v;
    int   kind;
    logic [31:0] r;
    kind = $urandom_range(0, 9);
    r = $urandom;
    v.ins  = (r == EBREAK) ? ~r : r;
    v.ty   = 3'($urandom_range(0, 5));
    r = $urandom;
    v.np   = r & 32'hFFFF_FFFC;
    v.rd   = $urandom_range(0, 3);
    v.sd   = $urandom_range(0, 3);
    v.dd   = $urandom_range(0, 3);
    v.spur = 1'($urandom_range(0, 1));
    if (kind == 0) begin
      v.ins = EBREAK;
      v.ty  = 3'($urandom_range(0, 7));
    end else if (kind == 1) begin
      v.ty = 3'($urandom_range(6, 7));
    end else if (kind == 2) begin
      v.np = (cur_pc & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
    end
    v.e_halt = 1'b0;
    v.e_code = 2'd0;
    if (v.ins == EBREAK) begin
      v.e_halt = 1'b1;
      v.e_code = 2'd0;
    end else if (v.ty >= 3'd6) begin
      v.e_halt = 1'b1;
      v.e_code = 2'd1;
    end else if (v.np[1:0] != 2'b00) begin
      v.e_halt = 1'b1;
      v.e_code = 2'd2;
    end
    v.e_wen = !v.e_halt && (v.ty == 3'd0 || v.ty == 3'd1 ||
                            v.ty == 3'd4 || v.ty == 3'd5);
    return v;
  endfunction

  initial begin
    vec_t v;
    tests = 0;
    fails = 0;
    clr_inputs();
    rst = 1'b1;
    #1;
    chk("por", 128'({imem_req_valid, imem_addr, inst, pc, retired,
                     halt, halt_code, exe_start, rf_wen}),
        128'({1'b1, RP, 32'h0, RP, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc   = RP;
    m_ret  = '0;
    m_inst = '0;

    tbl[0]  = '{32'h0010_0093, 3'd1, 32'h8000_0004, 0, 0, 0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[1]  = '{32'h0020_8133, 3'd0, 32'h8000_0008, 3, 2, 0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{32'h0020_a023, 3'd2, 32'h8000_000C, 0, 0, 3, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{32'h0020_8463, 3'd3, 32'h8000_0100, 1, 1, 1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{32'h1234_50b7, 3'd4, 32'h8000_0104, 0, 1, 0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[5]  = '{32'h0080_00ef, 3'd5, 32'h8000_0200, 2, 0, 2, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{EBREAK,        3'd6, 32'h8000_0204, 0, 0, 0, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{32'hFFFF_FFFF, 3'd6, 32'h8000_0004, 1, 0, 0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{32'h0000_0000, 3'd7, 32'h8000_0004, 0, 2, 0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{32'h0010_0093, 3'd1, 32'h8000_0006, 0, 0, 1, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[10] = '{32'h0010_0093, 3'd1, 32'h8000_0004, 0, 0, 0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[11] = '{EBREAK,        3'd1, 32'h8000_0008, 1, 1, 0, 1'b1, 1'b1, 2'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i]);
      if (tbl[i].e_halt) do_reset();
    end

    // Reset in the middle of a fetch handshake, then a late response
    run_instr(tbl[0]);
    imem_req_ready = 1'b1;
    #1;
    chk("wait_req", 128'({imem_req_valid, imem_addr}), 128'({1'b1, m_pc}));
    @(negedge clk);
    imem_req_ready = 1'b0;
    #1;
    chk("in_wait", 128'(imem_req_valid), 128'(1'b0));
    @(negedge clk);
    do_reset();
    v = '{32'h0000_0013, 3'd1, 32'h8000_0010, 2, 1, 0, 1'b1, 1'b0, 2'd0, 1'b1};
    run_instr(v);

    for (int n = 0; n < 40; n++) begin
      v = rand_vec(m_pc);
      run_instr(v);
      if (v.e_halt) do_reset();
    end

    #1;
    chk("final", 128'({pc, retired, halt}), 128'({m_pc, m_ret, 1'b0}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
